flp_adder_scheduler: RTL and testbench

Shares one pipelined floating-point adder (add-only configuration, fixed latency) between `NUM_REQ` requesters. Round-robin arbitration issues at most one operation per cycle; subtraction is done by flipping the sign of operand b. A tag pipeline tracks each operation's requester and routes the adder result back. The block sits between the HE arithmetic lanes and the single shared adder instance.

---
 rtl/flp_sched_pkg.sv | 23 ++
 rtl/flp_adder_scheduler_rr_arbiter.sv | 32 +++
 rtl/flp_adder_scheduler.sv | 148 ++++++++++++++
 tb/tb_flp_adder_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flp_sched_pkg.sv
// Shared types and helpers for the floating-point adder scheduler.
// OVERALL_BITS mirrors the value defined in CommonDefinitions.vh for the HE lanes.
package flp_sched_pkg;

  localparam int OVERALL_BITS = 64;
  localparam int MAX_REQ      = 8;
  localparam int IDX_W        = $clog2(MAX_REQ);

  // One entry of the tag pipeline: which requester owns the op in that slot.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Subtraction is a+(-b): negate an IEEE value by inverting its sign bit.
  function automatic logic [OVERALL_BITS-1:0] flip_sign(
    input logic [OVERALL_BITS-1:0] v,
    input logic                    en
  );
    return {v[OVERALL_BITS-1] ^ en, v[OVERALL_BITS-2:0]};
  endfunction

endpackage

// File: rtl/flp_adder_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic found;
  int   pos;

  // Scan N positions starting at ptr, wrapping; the first requester seen wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/flp_adder_scheduler.sv
// Shares one fixed-latency pipelined FP adder between NUM_REQ requesters.
// Requests are issued round-robin, tagged with their owner, and the adder
// result is routed back to the owner when the tag reaches the pipe head.
module flp_adder_scheduler
  import flp_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDER_LATENCY = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*OVERALL_BITS-1:0]      req_a,
  input  logic [NUM_REQ*OVERALL_BITS-1:0]      req_b,
  input  logic [NUM_REQ-1:0]                   req_sub,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [OVERALL_BITS-1:0]              rsp_result,
  output logic                                 adder_start,
  output logic [OVERALL_BITS-1:0]              adder_a,
  output logic [OVERALL_BITS-1:0]              adder_b,
  input  logic                                 adder_valid,
  input  logic [OVERALL_BITS-1:0]              adder_result,
  output logic [$clog2(ADDER_LATENCY+2)-1:0]   inflight,
  output logic                                 busy,
  output logic                                 tag_error
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int BW    = $clog2(ADDER_LATENCY + 1);
  localparam int INF_W = $clog2(ADDER_LATENCY + 2);

  logic [IW-1:0]           rr_ptr;
  logic [NUM_REQ-1:0]      grant;
  logic [IW-1:0]           grant_idx;
  logic                    xfer;
  logic [OVERALL_BITS-1:0] win_a;
  logic [OVERALL_BITS-1:0] win_b;
  logic                    win_sub;
  logic [IW-1:0]           issue_idx;
  tag_t                    tag_pipe [ADDER_LATENCY];
  tag_t                    head;
  logic [NUM_REQ-1:0]      head_onehot;
  logic [BW-1:0]           blank_cnt;
  logic                    mismatch;
  logic                    deliver;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The adder never stalls, so the arbiter grant is the accept, gated only by reset.
  assign req_ready = rst ? '0 : grant;
  assign xfer      = |(req_valid & req_ready);

  // Select the winning requester's operands.
  always_comb begin
    win_a   = req_a[int'(grant_idx)*OVERALL_BITS +: OVERALL_BITS];
    win_b   = req_b[int'(grant_idx)*OVERALL_BITS +: OVERALL_BITS];
    win_sub = req_sub[grant_idx];
  end

  // Round-robin pointer moves just past the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  // Issue register: one-cycle start strobe; operands hold between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      adder_start <= 1'b0;
      adder_a     <= '0;
      adder_b     <= '0;
      issue_idx   <= '0;
    end else begin
      adder_start <= xfer;
      if (xfer) begin
        adder_a   <= win_a;
        adder_b   <= flip_sign(win_b, win_sub);
        issue_idx <= grant_idx;
      end
    end
  end

  // Tag pipe follows the adder's own pipe so the head lines up with adder_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ADDER_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= {adder_start, IDX_W'(issue_idx)};
      for (int k = 1; k < ADDER_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign head = tag_pipe[ADDER_LATENCY-1];

  // Decode the head owner into a response strobe.
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) head_onehot[i] = (int'(head.idx) == i);
  end

  // The adder is not reset, so its valid pipe is ignored until stale ops drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= BW'(ADDER_LATENCY);
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - BW'(1);
    end
  end

  assign mismatch = (blank_cnt == '0) && (adder_valid != head.valid);
  assign deliver  = head.valid && !mismatch;

  // Registered response to the owner; a disagreeing result is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      tag_error  <= 1'b0;
    end else begin
      rsp_valid <= deliver ? head_onehot : '0;
      if (deliver) rsp_result <= adder_result;
      if (mismatch) tag_error <= 1'b1;
    end
  end

  // In-flight count: +1 per transfer, -1 per op leaving the tag head.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (xfer && !head.valid) begin
      inflight <= inflight + INF_W'(1);
    end else if (!xfer && head.valid) begin
      inflight <= inflight - INF_W'(1);
    end
  end

  assign busy = (inflight != '0);

endmodule

// File: tb/tb_flp_adder_scheduler.sv
module tb_flp_adder_scheduler;
  import flp_sched_pkg::*;

  localparam int N = 4;
  localparam int L = 4;
  localparam int W = OVERALL_BITS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_sub = '0;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           adder_start;
  logic [W-1:0]   adder_a, adder_b;
  logic           adder_valid;
  logic [W-1:0]   adder_result;
  logic [$clog2(L+2)-1:0] inflight;
  logic           busy, tag_error;

  flp_adder_scheduler #(.NUM_REQ(N), .ADDER_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .adder_start(adder_start), .adder_a(adder_a), .adder_b(adder_b),
    .adder_valid(adder_valid), .adder_result(adder_result),
    .inflight(inflight), .busy(busy), .tag_error(tag_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [W-1:0] rand_op();
    return $realtobits((real'($urandom_range(0, 4000)) - 2000.0) / 16.0);
  endfunction

  // Shared adder model: fixed L-cycle delay, no reset, plus a spurious-valid injector.
  logic         mv [L] = '{default: 1'b0};
  logic [W-1:0] mr [L] = '{default: '0};
  logic         spur = 1'b0;
  always @(posedge clk) begin
    mv[0] <= adder_start;
    mr[0] <= fp_add(adder_a, adder_b);
    for (int k = 1; k < L; k++) begin
      mv[k] <= mv[k-1];
      mr[k] <= mr[k-1];
    end
  end
  assign adder_valid  = mv[L-1] | spur;
  assign adder_result = mr[L-1];

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } iss_t;
  typedef struct { int idx; logic [W-1:0] res; int cyc; } rsp_t;

  iss_t exp_iss [$];
  rsp_t exp_rsp [$];
  int   total = 0, bad = 0;
  int   n_xfer = 0, n_rsp = 0, max_inf = 0;
  int   model_ptr = 0;
  int   last_xfer_cyc = 0;
  bit   chk_en = 1'b0;
  bit   exp_tag_err = 1'b0;
  logic [W-1:0] last_rsp_res = '0, last_adder_b = '0;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues or responds.
  iss_t mon_ie;
  rsp_t mon_re;
  always @(negedge clk) begin
    if (chk_en) begin
      if (adder_start) begin
        last_adder_b = adder_b;
        if (exp_iss.size() == 0) chk("unexpected issue", 64'(adder_start), 64'd0);
        else begin
          mon_ie = exp_iss.pop_front();
          chk("adder_a", adder_a, mon_ie.a);
          chk("adder_b", adder_b, mon_ie.b);
        end
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        last_rsp_res = rsp_result;
        if (exp_rsp.size() == 0) chk("unexpected rsp", 64'(rsp_valid), 64'd0);
        else begin
          mon_re = exp_rsp.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'd1 << mon_re.idx);
          chk("rsp_result", rsp_result, mon_re.res);
          chk("rsp_cycle", 64'(cyc), 64'(mon_re.cyc));
        end
      end
      chk("inflight", 64'(inflight), 64'(n_xfer - n_rsp));
      chk("busy", 64'(busy), 64'(n_xfer != n_rsp));
      chk("tag_error", 64'(tag_error), 64'(exp_tag_err));
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
    end
  end

  // One stimulus cycle: drive, check the grant against the round-robin rule, predict.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] s);
    int w, p;
    iss_t ie;
    rsp_t re;
    logic [N-1:0] exp_ready;
    @(negedge clk); #1;
    req_valid = v;
    req_sub   = s;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      p = (model_ptr + k) % N;
      if (w < 0 && v[p]) w = p;
    end
    exp_ready = (w < 0) ? '0 : (N'(1) << w);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (w >= 0) begin
      ie.a = opa[w];
      ie.b = s[w] ? $realtobits(-$bitstoreal(opb[w])) : opb[w];
      exp_iss.push_back(ie);
      re.idx = w;
      re.res = fp_add(ie.a, ie.b);
      re.cyc = cyc + L + 2;
      exp_rsp.push_back(re);
      n_xfer++;
      model_ptr = (w + 1) % N;
      last_xfer_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  // One-cycle reset; in-flight ops are discarded so the scoreboard is flushed.
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    req_valid = '1;
    chk_en = 1'b0;
    #1;
    chk("req_ready in reset", 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_result", rsp_result, 64'd0);
    chk("reset adder_start", 64'(adder_start), 64'd0);
    chk("reset adder_a", adder_a, 64'd0);
    chk("reset adder_b", adder_b, 64'd0);
    chk("reset inflight", 64'(inflight), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset tag_error", 64'(tag_error), 64'd0);
    rst = 1'b0;
    req_valid = '0;
    exp_iss.delete();
    exp_rsp.delete();
    n_xfer = 0;
    n_rsp = 0;
    model_ptr = 0;
    exp_tag_err = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    int lx;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (2) @(posedge clk);
    do_reset();

    // Single add from requester 2: 1.0 + 2.0
    opa[2] = 64'h3FF0000000000000;
    opb[2] = 64'h4000000000000000;
    step(4'b0100, 4'b0000);
    idle(8);
    chk("single add result", last_rsp_res, 64'h4008000000000000);

    // Subtraction from requester 0: 3.0 - 1.0
    opa[0] = 64'h4008000000000000;
    opb[0] = 64'h3FF0000000000000;
    step(4'b0001, 4'b0001);
    idle(8);
    chk("sub adder_b", last_adder_b, 64'hBFF0000000000000);
    chk("sub result", last_rsp_res, 64'h4000000000000000);

    // Fairness and sustained traffic from a fresh pointer
    do_reset();
    max_inf = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = rand_op();
        opb[i] = rand_op();
      end
      step(4'b1111, N'($urandom_range(0, 15)));
    end
    lx = last_xfer_cyc;
    while (cyc < lx + 7) begin
      step('0, '0);
      if (cyc == lx + 5) chk("busy before drain", 64'(busy), 64'd1);
      if (cyc == lx + 6) chk("busy after drain", 64'(busy), 64'd0);
    end
    chk("inflight peak", 64'(max_inf), 64'(L + 1));

    // Reset with three ops in flight; stale adder outputs must be blanked
    for (int c = 0; c < 3; c++) begin
      opa[c] = rand_op();
      opb[c] = rand_op();
      step(N'(1) << c, '0);
    end
    do_reset();
    idle(10);

    // Spurious adder_valid with an empty tag pipe
    @(negedge clk); #1;
    spur = 1'b1;
    exp_tag_err = 1'b1;
    @(negedge clk); #1;
    spur = 1'b0;
    idle(6);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = rand_op();
        opb[i] = rand_op();
      end
      step(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
    end
    idle(10);
    chk("rsp queue drained", 64'(exp_rsp.size()), 64'd0);
    chk("issue queue drained", 64'(exp_iss.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
